// File: rtl/frame_ser_pkg.sv
// frame_ser_pkg: shared FSM state type and index-width helper for frame_serializer.
// Contents:
//   state_t   - serializer FSM states IDLE/STREAM
//   idx_width - beat index width able to hold 0..stage
package frame_ser_pkg;

   typedef enum logic {IDLE, STREAM} state_t;

   function automatic int idx_width(input int stage);
      return $clog2(stage + 1);
   endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// frame_serializer_if: valid/ready beat stream carrying one frame word per beat.
// Signals:
//   m_data  - beat word           m_valid - beat valid
//   m_ready - consumer accept     m_last  - final beat of frame
//   m_idx   - beat index within frame
// Modports: master (serializer side), slave (consumer side).
interface frame_ser_if #(
   parameter int STAGE  = 8,
   parameter int DWIDTH = 8
) ();

   localparam int IDXW = frame_ser_pkg::idx_width(STAGE);

   logic [DWIDTH-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic [IDXW-1:0]   m_idx;

   modport master(output m_data, m_valid, m_last, m_idx, input m_ready);
   modport slave(input m_data, m_valid, m_last, m_idx, output m_ready);

endinterface

// File: rtl/frame_serializer_stb_edge_det.sv
// stb_edge_det: registered rising-edge detector for a level strobe.
// Ports:
//   clk  - clock            rst  - asynchronous active-low reset
//   stb  - strobe level     rise - high for the cycle in which stb goes 0->1
module stb_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic stb,
   output logic rise
);

   logic stb_q;
   logic stb_d;

   always_comb stb_d = stb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stb_q <= 1'b0;
      else      stb_q <= stb_d;
   end

   assign rise = stb & ~stb_q;

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: double-buffered parallel-frame to valid/ready word-stream serializer.
// Ports:
//   clk        - clock                     rst     - asynchronous active-low reset
//   frame_stb  - frame strobe (rising edge = new frame)
//   frame_data - STAGE parallel words, word 0 streamed first
//   m          - frame_ser_if.master beat stream
//   busy       - active slot holds a frame  ovf     - sticky frame-dropped flag
//   ovf_clr    - synchronous clear of ovf
// Build option: FRAME_SER_CHECKSUM_EN appends a mod-2^DWIDTH word-sum beat to each frame.
module frame_serializer #(
   parameter int STAGE  = 8,
   parameter int DWIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_stb,
   input  logic [0:STAGE-1][DWIDTH-1:0]  frame_data,
   frame_ser_if.master                   m,
   output logic                          busy,
   output logic                          ovf,
   input  logic                          ovf_clr
);

   import frame_ser_pkg::*;

   localparam int IDXW  = idx_width(STAGE);
   localparam int WIDXW = $clog2(STAGE);
`ifdef FRAME_SER_CHECKSUM_EN
   localparam int LAST = STAGE;
`else
   localparam int LAST = STAGE - 1;
`endif

   typedef logic [0:STAGE-1][DWIDTH-1:0] frame_t;

   state_t          state_q, state_d;
   frame_t          act_q, act_d, pend_q, pend_d;
   logic            pend_full_q, pend_full_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            ovf_q, ovf_d;
   logic            new_frame, fire, last_fire, drop;
   logic            ld_act_in, ld_act_pend, ld_pend;
   logic [WIDXW-1:0] widx;
   logic [DWIDTH-1:0] word;

   stb_edge_det u_stb_edge_det (
      .clk  (clk),
      .rst  (rst),
      .stb  (frame_stb),
      .rise (new_frame)
   );

   assign widx      = idx_q[WIDXW-1:0];
   assign fire      = (state_q == STREAM) & m.m_ready;
   assign last_fire = fire & (idx_q == IDXW'(LAST));

`ifdef FRAME_SER_CHECKSUM_EN
   logic [DWIDTH-1:0] act_sum_q, act_sum_d, pend_sum_q, pend_sum_d, in_sum;

   always_comb begin
      in_sum = '0;
      for (int i = 0; i < STAGE; i++) in_sum = in_sum + frame_data[i];
   end

   always_comb begin
      act_sum_d  = ld_act_pend ? pend_sum_q : ld_act_in ? in_sum : act_sum_q;
      pend_sum_d = ld_pend ? in_sum : pend_sum_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_sum_q  <= '0;
         pend_sum_q <= '0;
      end else begin
         act_sum_q  <= act_sum_d;
         pend_sum_q <= pend_sum_d;
      end
   end

   // Beat index STAGE is the appended checksum beat.
   assign word = (idx_q == IDXW'(STAGE)) ? act_sum_q : act_q[widx];
`else
   assign word = act_q[widx];
`endif

   assign m.m_valid = (state_q == STREAM);
   assign m.m_data  = (state_q == STREAM) ? word : '0;
   assign m.m_idx   = idx_q;
   assign m.m_last  = (state_q == STREAM) & (idx_q == IDXW'(LAST));
   assign busy      = (state_q == STREAM);
   assign ovf       = ovf_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pend_full_d = pend_full_q;
      ld_act_in   = 1'b0;
      ld_act_pend = 1'b0;
      ld_pend     = 1'b0;
      drop        = 1'b0;
      if (state_q == IDLE) begin
         if (new_frame) begin
            ld_act_in = 1'b1;
            idx_d     = '0;
            state_d   = STREAM;
         end
      end else if (last_fire) begin
         // Frame completes: refill from pending, else straight from the input, else go idle.
         idx_d = '0;
         if (pend_full_q) begin
            ld_act_pend = 1'b1;
            ld_pend     = new_frame;
            pend_full_d = new_frame;
         end else if (new_frame) begin
            ld_act_in = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else begin
         if (fire) idx_d = idx_q + IDXW'(1);
         if (new_frame) begin
            drop        = pend_full_q;
            ld_pend     = ~pend_full_q;
            pend_full_d = 1'b1;
         end
      end
      act_d  = ld_act_pend ? pend_q : ld_act_in ? frame_data : act_q;
      pend_d = ld_pend ? frame_data : pend_q;
      ovf_d  = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         act_q       <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         idx_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         idx_q       <= idx_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed self-checking bench for frame_serializer (STAGE=8, DWIDTH=8).
module tb_frame_serializer;

   localparam int STAGE  = 8;
   localparam int DWIDTH = 8;
`ifdef FRAME_SER_CHECKSUM_EN
   localparam int NB = STAGE + 1;
`else
   localparam int NB = STAGE;
`endif

   typedef logic [0:STAGE-1][DWIDTH-1:0] frame_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   frame_stb = 1'b0;
   logic   ovf_clr = 1'b0;
   frame_t frame_data = '0;
   logic   busy, ovf;
   int     checks = 0;
   int     errors = 0;

   frame_ser_if #(.STAGE(STAGE), .DWIDTH(DWIDTH)) ifc ();

   frame_serializer #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_stb  (frame_stb),
      .frame_data (frame_data),
      .m          (ifc),
      .busy       (busy),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic frame_t ramp(input logic [7:0] b);
      frame_t f;
      for (int i = 0; i < STAGE; i++) f[i] = b + 8'(i);
      return f;
   endfunction

   function automatic logic [7:0] beat(input frame_t f, input int k);
      logic [7:0] s = '0;
      if (k < STAGE) return f[k];
      for (int i = 0; i < STAGE; i++) s = s + f[i];
      return s;
   endfunction

   task automatic strobe(input frame_t f, input int dly, input int hold);
      repeat (dly) @(negedge clk);
      frame_data = f;
      frame_stb  = 1'b1;
      repeat (hold) @(negedge clk);
      frame_stb  = 1'b0;
   endtask

   // Expects a valid beat on every sampled cycle; pat 0 = always ready, pat 1 = ready 1,0,0,...
   task automatic stream(input frame_t f, input int pat, input int nb, input string tag);
      int k = 0;
      int c = 0;
      while (k < nb && c < 4 * NB + 8) begin
         @(negedge clk);
         check({tag, " valid"}, 32'(ifc.m_valid), 32'd1);
         check({tag, " data"}, 32'(ifc.m_data), 32'(beat(f, k)));
         check({tag, " idx"}, 32'(ifc.m_idx), 32'(k));
         check({tag, " last"}, 32'(ifc.m_last), 32'(k == NB - 1));
         check({tag, " busy"}, 32'(busy), 32'd1);
         ifc.m_ready = (pat == 0) || (c % 3 == 0);
         if (ifc.m_valid && ifc.m_ready) k++;
         c++;
      end
      check({tag, " beats"}, 32'(k), 32'(nb));
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      check({tag, " valid"}, 32'(ifc.m_valid), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " last"}, 32'(ifc.m_last), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifc.m_ready = 1'b1;
      #2;
      check("rst valid", 32'(ifc.m_valid), 32'd0);
      check("rst data", 32'(ifc.m_data), 32'd0);
      check("rst last", 32'(ifc.m_last), 32'd0);
      check("rst idx", 32'(ifc.m_idx), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst ovf", 32'(ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      fork strobe(ramp(8'h10), 0, 1); join_none
      stream(ramp(8'h10), 0, NB, "single");
      expect_idle("single end");

      repeat (2) @(negedge clk);
      fork strobe(ramp(8'h20), 0, 1); join_none
      stream(ramp(8'h20), 1, NB, "bp");
      expect_idle("bp end");

      repeat (2) @(negedge clk);
      fork
         strobe(ramp(8'h30), 0, 1);
         strobe(ramp(8'h40), 2, 1);
         strobe(ramp(8'h50), 4, 1);
      join_none
      stream(ramp(8'h30), 0, NB, "b2b a");
      stream(ramp(8'h40), 0, NB, "b2b b");
      check("drop ovf set", 32'(ovf), 32'd1);
      expect_idle("drop c");
      check("drop ovf held", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf clr", 32'(ovf), 32'd0);

      repeat (2) @(negedge clk);
      fork
         strobe(ramp(8'h60), 0, 1);
         strobe(ramp(8'h70), NB, 1);
      join_none
      stream(ramp(8'h60), 0, NB, "edge a");
      stream(ramp(8'h70), 0, NB, "edge b");
      check("edge ovf", 32'(ovf), 32'd0);
      expect_idle("edge end");

      repeat (2) @(negedge clk);
      fork strobe(ramp(8'h80), 0, 20); join_none
      stream(ramp(8'h80), 0, NB, "hold");
      for (int i = 0; i < 24 - NB; i++) expect_idle("hold after");

      repeat (2) @(negedge clk);
      fork strobe(ramp(8'h90), 0, 1); join_none
      stream(ramp(8'h90), 0, 3, "rst pre");
      @(negedge clk);
      check("rst mid data", 32'(ifc.m_data), 32'h93);
      check("rst mid idx", 32'(ifc.m_idx), 32'd3);
      rst = 1'b0;
      #1;
      check("rst now valid", 32'(ifc.m_valid), 32'd0);
      check("rst now data", 32'(ifc.m_data), 32'd0);
      check("rst now idx", 32'(ifc.m_idx), 32'd0);
      check("rst now last", 32'(ifc.m_last), 32'd0);
      check("rst now busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) expect_idle("rst after");
      fork strobe(ramp(8'hA0), 0, 1); join_none
      stream(ramp(8'hA0), 0, NB, "post rst");
      expect_idle("post rst end");

`ifdef FRAME_SER_CHECKSUM_EN
      repeat (2) @(negedge clk);
      fork strobe({STAGE{8'hFF}}, 0, 1); join_none
      stream({STAGE{8'hFF}}, 0, NB, "sum");
      check("sum beat", 32'(beat({STAGE{8'hFF}}, STAGE)), 32'hF8);
      expect_idle("sum end");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
